// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD timing receiver and its statistics block.
package lcd_rx_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } rx_state_t;

   localparam int DEF_H_ACT = 800;
   localparam int DEF_V_ACT = 480;

   localparam int               CNT_W   = 11;
   localparam logic [CNT_W-1:0] CNT_SAT = 11'd2047;

endpackage

// File: rtl/lcd_rx_stats.sv
// Line/frame period measurement: ticks between HSFs and HSF count between VSFs.
// Built only when LCD_RX_STATS_EN is defined.
module lcd_rx_stats
   import lcd_rx_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             hsf,
   input  logic             vsf,
   output logic [CNT_W-1:0] meas_h_total,
   output logic [CNT_W-1:0] meas_v_total
);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_seen;
   logic             v_seen;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   // The first period after reset starts mid-stream, so it is never published.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         h_seen       <= 1'b0;
         v_seen       <= 1'b0;
         meas_h_total <= '0;
         meas_v_total <= '0;
      end else if (tick) begin
         if (hsf) begin
            if (h_seen) meas_h_total <= h_cnt;
            h_seen <= 1'b1;
            h_cnt  <= 11'd1;
         end else begin
            h_cnt <= sat_inc(h_cnt);
         end

         // An HSF coincident with the VSF belongs to the new frame.
         if (vsf) begin
            if (v_seen) meas_v_total <= v_cnt;
            v_seen <= 1'b1;
            v_cnt  <= hsf ? 11'd1 : 11'd0;
         end else if (hsf) begin
            v_cnt <= sat_inc(v_cnt);
         end
      end
   end

endmodule

// File: rtl/lcd_timing_receiver.sv
// Parallel TFT sink: recovers pixel coordinates, verifies geometry, forwards pixels while locked.
// Optional period statistics are built when LCD_RX_STATS_EN is defined.
module lcd_timing_receiver
   import lcd_rx_pkg::*;
#(
   parameter int H_ACT         = DEF_H_ACT,
   parameter int V_ACT         = DEF_V_ACT,
   parameter int FRAME_TIMEOUT = 1048575
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             hs_n,
   input  logic             vs_n,
   input  logic             data_enable,
   input  logic [23:0]      pixel,
   output logic             locked,
   output logic             frame_start,
   output logic [7:0]       error_count,
   output logic             px_valid,
   output logic [9:0]       px_x,
   output logic [9:0]       px_y,
   output logic [23:0]      px_data,
   output logic [CNT_W-1:0] meas_h_total,
   output logic [CNT_W-1:0] meas_v_total
);

   localparam logic [CNT_W-1:0] H_ACT_W  = H_ACT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] V_ACT_W  = V_ACT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] V_ACT_P1 = V_ACT_W + 1'b1;
   localparam logic [19:0]      TO_W     = FRAME_TIMEOUT[19:0];

   rx_state_t        state;
   rx_state_t        state_nxt;
   logic             hs_q;
   logic             vs_q;
   logic             de_q;
   logic [CNT_W-1:0] x_cnt;
   logic [CNT_W-1:0] y_cnt;
   logic [CNT_W-1:0] x_cur;
   logic [CNT_W-1:0] y_inc;
   logic [CNT_W-1:0] y_eff;
   logic             line_bad;
   logic [19:0]      to_cnt;
   logic [19:0]      to_inc;
   logic             vsf;
   logic             hsf;
   logic             der;
   logic             def;
   logic             len_bad;
   logic             y_over;
   logic             timeout;
   logic             frame_good;
   logic             lose;
   logic             err_inc;
   logic             fwd;
   logic             fs_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Event decode and geometry checks on the current tick
   always_comb begin
      vsf     = tick & vs_q & ~vs_n;
      hsf     = tick & hs_q & ~hs_n;
      der     = tick & ~de_q & data_enable;
      def     = tick & de_q & ~data_enable;
      x_cur   = der ? '0 : x_cnt;
      y_inc   = sat_inc(y_cnt);
      // The frame check sees a DEF landing on the same tick as the VSF.
      y_eff   = def ? y_inc : y_cnt;
      len_bad = def & (x_cnt != H_ACT_W);
      y_over  = def & (y_inc == V_ACT_P1);
      frame_good = (y_eff == V_ACT_W) & ~line_bad & ~len_bad;
      to_inc  = to_cnt + 20'd1;
      timeout = tick & ~vsf & (to_inc == TO_W);
   end

   always_comb begin
      state_nxt = state;
      err_inc   = 1'b0;
      lose      = 1'b0;
      unique case (state)
         SEARCH: begin
            if (timeout) err_inc = 1'b1;
            else if (vsf) state_nxt = CHECK;
         end
         CHECK: begin
            if (timeout) begin
               err_inc   = 1'b1;
               state_nxt = SEARCH;
            end else if (vsf) begin
               state_nxt = frame_good ? LOCKED : CHECK;
            end
         end
         LOCKED: begin
            if (len_bad | y_over | (vsf & (y_eff != V_ACT_W)) | timeout) begin
               lose      = 1'b1;
               err_inc   = 1'b1;
               state_nxt = SEARCH;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // Lines beyond V_ACT are never forwarded, even before the overrun is detected.
   always_comb begin
      fwd    = tick & data_enable & (state == LOCKED) & ~lose
               & (x_cur < H_ACT_W) & (y_cnt < V_ACT_W);
      fs_nxt = vsf & (state == LOCKED) & (state_nxt == LOCKED);
   end

   // Control state: sampled history, counters, FSM
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= SEARCH;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         de_q        <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         line_bad    <= 1'b0;
         to_cnt      <= '0;
         error_count <= '0;
         locked      <= 1'b0;
      end else if (tick) begin
         hs_q  <= hs_n;
         vs_q  <= vs_n;
         de_q  <= data_enable;
         if (data_enable) x_cnt <= sat_inc(x_cur);
         if (vsf) y_cnt <= '0;
         else if (def) y_cnt <= y_inc;
         if (vsf) line_bad <= 1'b0;
         else if (len_bad) line_bad <= 1'b1;
         to_cnt <= (vsf | timeout) ? '0 : to_inc;
         state  <= state_nxt;
         locked <= (state_nxt == LOCKED);
         if (err_inc) error_count <= sat_inc8(error_count);
      end
   end

   // Output stage: strobes every clock, pixel fields only on forwarded ticks
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         px_valid    <= 1'b0;
         frame_start <= 1'b0;
         px_x        <= '0;
         px_y        <= '0;
         px_data     <= '0;
      end else begin
         px_valid    <= fwd;
         frame_start <= fs_nxt;
         if (fwd) begin
            px_x    <= x_cur[9:0];
            px_y    <= y_cnt[9:0];
            px_data <= pixel;
         end
      end
   end

`ifdef LCD_RX_STATS_EN
   lcd_rx_stats u_stats (
      .clock        (clock),
      .reset_n      (reset_n),
      .tick         (tick),
      .hsf          (hsf),
      .vsf          (vsf),
      .meas_h_total (meas_h_total),
      .meas_v_total (meas_v_total)
   );
`else
   logic stats_unused;
   assign stats_unused = hsf;
   assign meas_h_total = '0;
   assign meas_v_total = '0;
`endif

endmodule
